// File: rtl/dmem_arbiter_if.sv
// Request/response and DMEM bus bundle for dmem_arbiter.
// slave = arbiter view, master = requesters/memory environment view.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_stall;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_lock;
    logic                  dma_gnt;
    logic                  dma_rvalid;
    logic [DATA_WIDTH-1:0] dma_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/DMA arbiter for the single-ported DMEM with bounded locked DMA bursts.
// Define DMEM_ARB_ROUND_ROBIN_EN for alternating conflict resolution; default favours the core.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    typedef enum logic {OWNER_CPU, OWNER_DMA} owner_e;

    owner_e                last_owner_q, last_owner_d;
    logic                  locked_q, locked_d;
    logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
    logic                  cpu_rvalid_q, cpu_rvalid_d;
    logic                  dma_rvalid_q, dma_rvalid_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

    logic                  cpu_gnt, dma_gnt, conflict_to_dma, lock_hold;

    always_comb begin
        cpu_gnt         = 1'b0;
        dma_gnt         = 1'b0;
        conflict_to_dma = RoundRobin && (last_owner_q == OWNER_CPU);
        lock_hold       = locked_q && (lock_cnt_q < LOCK_MAX_C);
        if (bus.cpu_req && bus.dma_req) begin
            if (locked_q) begin
                dma_gnt = lock_hold;
                cpu_gnt = !lock_hold;
            end else begin
                dma_gnt = conflict_to_dma;
                cpu_gnt = !conflict_to_dma;
            end
        end else begin
            cpu_gnt = bus.cpu_req;
            dma_gnt = bus.dma_req;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        locked_d     = locked_q;
        lock_cnt_d   = lock_cnt_q;
        cpu_rvalid_d = cpu_gnt && !bus.cpu_we;
        dma_rvalid_d = dma_gnt && !bus.dma_we;
        cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;
        dma_rdata_d  = dma_rvalid_d ? bus.mem_rdata : dma_rdata_q;

        if (cpu_gnt) last_owner_d = OWNER_CPU;
        if (dma_gnt) last_owner_d = OWNER_DMA;

        if (dma_gnt && bus.dma_lock) locked_d = 1'b1;
        else if (!bus.dma_lock || !bus.dma_req) locked_d = 1'b0;

        // The grant that takes the lock already counts against the waiting core.
        if (dma_gnt && bus.dma_lock && bus.cpu_req) lock_cnt_d = lock_cnt_q + CW'(1);
        else if (cpu_gnt || !bus.cpu_req || !locked_d) lock_cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner_q <= OWNER_DMA;
            locked_q     <= 1'b0;
            lock_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            locked_q     <= locked_d;
            lock_cnt_q   <= lock_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.cpu_stall  = bus.cpu_req && !cpu_gnt;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dma_rdata  = dma_rdata_q;

    assign bus.mem_read   = (cpu_gnt && !bus.cpu_we) || (dma_gnt && !bus.dma_we);
    assign bus.mem_write  = (cpu_gnt && bus.cpu_we) || (dma_gnt && bus.dma_we);
    assign bus.mem_addr   = cpu_gnt ? bus.cpu_addr  : (dma_gnt ? bus.dma_addr  : '0);
    assign bus.mem_wdata  = cpu_gnt ? bus.cpu_wdata : (dma_gnt ? bus.dma_wdata : '0);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboarded random/directed bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LM = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Environment memory, written only through the DUT strobes (or preload).
    logic [31:0] dmem [64];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];
    always @(posedge clk) begin
        if (pre_we) dmem[pre_idx] <= pre_data;
        else if (bus.mem_write) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct {int due; logic [31:0] data;} rsp_t;
    rsp_t        cpu_q[$];
    rsp_t        dma_q[$];
    logic [31:0] ref_mem [64];
    int          m_last   = 1;     // 0 = core served last, 1 = DMA
    bit          m_burst  = 1'b0;  // DMA currently owns a locked burst
    int          m_streak = 0;     // locked DMA slots the waiting core has sat through
    logic [31:0] m_cpu_rdata = '0;
    logic [31:0] m_dma_rdata = '0;
    bit          exp_cpu_gnt, exp_dma_gnt;
    bit          mon_en = 1'b0;

    always @(negedge clk) if (mon_en) begin
        bit cg, dg;
        logic [31:0] ea, ewd;
        bit er, ew;
        cg = 1'b0; dg = 1'b0;
        if (bus.cpu_req && bus.dma_req) begin
            if (m_burst) begin
                if (m_streak < LM) dg = 1'b1; else cg = 1'b1;
            end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                if (m_last == 0) dg = 1'b1; else cg = 1'b1;
`else
                cg = 1'b1;
`endif
            end
        end else begin
            cg = bus.cpu_req;
            dg = bus.dma_req;
        end
        exp_cpu_gnt = cg;
        exp_dma_gnt = dg;

        ea = '0; ewd = '0; er = 1'b0; ew = 1'b0;
        if (cg) begin ea = bus.cpu_addr; ewd = bus.cpu_wdata; ew = bus.cpu_we; er = !bus.cpu_we; end
        if (dg) begin ea = bus.dma_addr; ewd = bus.dma_wdata; ew = bus.dma_we; er = !bus.dma_we; end

        chk("cpu_gnt",   32'(bus.cpu_gnt),   32'(cg));
        chk("dma_gnt",   32'(bus.dma_gnt),   32'(dg));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !cg));
        chk("mem_read",  32'(bus.mem_read),  32'(er));
        chk("mem_write", 32'(bus.mem_write), 32'(ew));
        chk("mem_addr",  bus.mem_addr,  ea);
        chk("mem_wdata", bus.mem_wdata, ewd);

        if (er && !rst) begin
            if (cg) cpu_q.push_back('{cyc + 1, ref_mem[ea[7:2]]});
            else    dma_q.push_back('{cyc + 1, ref_mem[ea[7:2]]});
        end
        if (ew) ref_mem[ea[7:2]] = ewd;

        if (rst) begin
            m_last = 1; m_burst = 1'b0; m_streak = 0;
        end else begin
            if (cg) m_last = 0;
            if (dg) m_last = 1;
            if (dg && bus.dma_lock) m_burst = 1'b1;
            else if (!bus.dma_lock || !bus.dma_req) m_burst = 1'b0;
            if (!bus.cpu_req || cg || !m_burst) m_streak = 0;
            else if (dg && bus.dma_lock) m_streak++;
        end
    end

    // Response monitor: pops expected reads when they fall due.
    always @(negedge clk) if (mon_en) begin
        bit ev;
        ev = (cpu_q.size() > 0) && (cpu_q[0].due == cyc);
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(ev));
        if (ev) begin m_cpu_rdata = cpu_q[0].data; void'(cpu_q.pop_front()); end
        chk("cpu_rdata", bus.cpu_rdata, m_cpu_rdata);
        ev = (dma_q.size() > 0) && (dma_q[0].due == cyc);
        chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(ev));
        if (ev) begin m_dma_rdata = dma_q[0].data; void'(dma_q.pop_front()); end
        chk("dma_rdata", bus.dma_rdata, m_dma_rdata);
        if (rst) begin m_cpu_rdata = '0; m_dma_rdata = '0; end
    end

    function automatic logic [31:0] rnd_addr();
        logic [5:0] w;
        w = 6'($urandom_range(0, 63));
        return {24'h0, w, 2'b00};
    endfunction

    task automatic cyc_drive(input logic cr, input logic cwe, input logic [31:0] ca,
                             input logic [31:0] cwd, input logic dr, input logic dwe,
                             input logic [31:0] da, input logic [31:0] dwd,
                             input logic dl, input logic r);
        @(posedge clk); #1;
        bus.cpu_req = cr; bus.cpu_we = cwe; bus.cpu_addr = ca; bus.cpu_wdata = cwd;
        bus.dma_req = dr; bus.dma_we = dwe; bus.dma_addr = da; bus.dma_wdata = dwd;
        bus.dma_lock = dl; rst = r;
        @(negedge clk); #1;
    endtask

    task automatic idle(input logic r);
        cyc_drive(0, 0, '0, '0, 0, 0, '0, '0, 0, r);
    endtask

    initial begin
        logic [3:0]  cseq;
        logic [19:0] lseq;
        int          dcnt;
        bit          cpu_busy, dma_busy;

        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.dma_lock = 0;

        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'hDEADBEEF;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            pre_we = 1'b1; pre_idx = 6'(i); pre_data = ref_mem[i];
        end
        @(posedge clk); #1;
        pre_we = 1'b0;
        mon_en = 1'b1;

        // Reset state
        idle(1);
        idle(0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("rst_dma_rdata",  bus.dma_rdata, 0);
        chk("rst_cpu_gnt",    32'(bus.cpu_gnt), 0);

        // Uncontested read
        cyc_drive(1, 0, 32'h10, '0, 0, 0, '0, '0, 0, 0);
        chk("unc_cpu_gnt",  32'(bus.cpu_gnt), 1);
        chk("unc_mem_read", 32'(bus.mem_read), 1);
        chk("unc_stall",    32'(bus.cpu_stall), 0);
        idle(0);
        chk("unc_rvalid", 32'(bus.cpu_rvalid), 1);
        chk("unc_rdata",  bus.cpu_rdata, 32'hDEADBEEF);

        // Conflict after reset
        idle(1);
        for (int i = 0; i < 4; i++) begin
            cyc_drive(1, 0, 32'h8, '0, 1, 0, 32'hC, '0, 0, 0);
            cseq[i] = bus.cpu_gnt;
        end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        chk("conflict_seq", 32'(cseq), 32'h5);
`else
        chk("conflict_seq", 32'(cseq), 32'hF);
`endif

        // Locked burst bounded by LOCK_MAX
        idle(1);
        cyc_drive(0, 0, '0, '0, 1, 0, rnd_addr(), '0, 1, 0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_drive(1, 0, rnd_addr(), '0, 1, 0, rnd_addr(), '0, 1, 0);
            lseq[i] = bus.cpu_gnt;
            if (bus.dma_gnt) dcnt++;
        end
        chk("lock_cpu_slots", 32'(lseq), 32'h20100);
        chk("lock_dma_count", 32'(dcnt), 18);

        // Write path
        cyc_drive(0, 0, '0, '0, 1, 1, 32'h40, 32'h12345678, 0, 0);
        chk("wr_dma_gnt",   32'(bus.dma_gnt), 1);
        chk("wr_mem_write", 32'(bus.mem_write), 1);
        chk("wr_mem_addr",  bus.mem_addr, 32'h40);
        chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
        cyc_drive(1, 0, 32'h40, '0, 0, 0, '0, '0, 0, 0);
        chk("wr_rd_gnt", 32'(bus.cpu_gnt), 1);
        idle(0);
        chk("wr_rd_data", bus.cpu_rdata, 32'h12345678);

        // Reset in the middle of a locked burst
        cyc_drive(0, 0, '0, '0, 1, 0, 32'h20, '0, 1, 0);
        cyc_drive(1, 0, 32'h24, '0, 1, 0, 32'h28, '0, 1, 1);
        chk("mid_dma_gnt", 32'(bus.dma_gnt), 1);
        cyc_drive(1, 0, 32'h24, '0, 1, 0, 32'h28, '0, 1, 0);
        chk("mid_dma_rvalid", 32'(bus.dma_rvalid), 0);
        chk("mid_cpu_gnt",    32'(bus.cpu_gnt), 1);
        chk("mid_dma_held",   32'(bus.dma_gnt), 0);

        // Idle
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("idle_strobes", {30'b0, bus.mem_read, bus.mem_write}, 0);
            chk("idle_gnts",    {30'b0, bus.cpu_gnt, bus.dma_gnt}, 0);
        end

        // Random traffic
        cpu_busy = 1'b0; dma_busy = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            if (!cpu_busy && $urandom_range(0, 3) != 0) begin
                cpu_busy = 1'b1;
                bus.cpu_we = ($urandom_range(0, 2) == 0);
                bus.cpu_addr = rnd_addr();
                bus.cpu_wdata = $urandom;
            end
            if (!dma_busy && $urandom_range(0, 2) != 0) begin
                dma_busy = 1'b1;
                bus.dma_we = ($urandom_range(0, 2) == 0);
                bus.dma_addr = rnd_addr();
                bus.dma_wdata = $urandom;
            end
            bus.cpu_req = cpu_busy;
            bus.dma_req = dma_busy;
            if ($urandom_range(0, 9) == 0) bus.dma_lock = !bus.dma_lock;
            @(negedge clk); #1;
            if (exp_cpu_gnt) cpu_busy = 1'b0;
            if (exp_dma_gnt) dma_busy = 1'b0;
        end

        idle(0);
        idle(0);
        chk("cpu_q_drained", 32'(cpu_q.size()), 0);
        chk("dma_q_drained", 32'(dma_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
